side_panel_bars: RTL and testbench
==================================

Name: side_panel_bars

Overview:
- Pixel-rate renderer for the right-hand status panel of the 640x480 display.
- Draws a parametrised stack of horizontal indicator bars (lives/level) on the panel background.
- Latches the requested bar count once per frame, so there is no mid-frame tearing.
- Blinks gained or lost bars for a fixed number of frames after each change.
- Output is registered with 1-cycle latency. It feeds the top-level RGB mux alongside the play-field renderer.

Parameters:
- NBARS, 5, maximum number of bars drawn (1..15).
- LW, 4, width of level input.
- PANEL_X, 480, panel region is h > PANEL_X.
- BAR_X_LO, 540, bar columns satisfy BAR_X_LO < h < BAR_X_HI.
- BAR_X_HI, 580, see BAR_X_LO.
- BAR_Y0, 455, bar 0 occupies rows BAR_Y0+1 .. BAR_Y0+BAR_H.
- BAR_H, 4, bar height in rows.
- BAR_PITCH, 10, vertical spacing. Bar k sits BAR_PITCH*k rows above bar 0.
- BLINK_PERIOD, 8, frames per blink half-phase; must be a power of two.
- BLINK_FRAMES, 32, total blink duration in frames.
- COL_BG, 24'h000000, colour outside the panel.
- COL_PANEL, 24'h880000, panel background colour.
- COL_BAR, 24'h99FFFF, bar colour.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- h  in  10  current pixel column.
- v  in  10  current pixel row.
- level  in  LW  requested bar count; values above NBARS saturate to NBARS.
- rgb  out  24  registered pixel colour for the (h,v) presented on the previous cycle.
- blinking  out  1  high while in the BLINK state.

Behaviour:
- Reset (async, rst_n=0):
  - rgb=0, blinking=0.
  - shown=0, prev=0, frame_cnt=0, state=IDLE.
  - Reset takes effect immediately, including mid-blink and mid-frame.
- Frame start: a cycle with h==0 && v==0. All level sampling and frame counting happen only on frame start.
- Saturation: lvl_s = min(level, NBARS).
- IDLE state, on frame start:
  - If lvl_s != shown: prev<=shown, shown<=lvl_s, frame_cnt<=0, go to BLINK.
  - Otherwise no change.
- BLINK state, on frame start:
  - If lvl_s != shown: restart. prev<=shown, shown<=lvl_s, frame_cnt<=0, stay in BLINK.
  - Else if frame_cnt == BLINK_FRAMES-1: go to IDLE, prev<=shown.
  - Else frame_cnt<=frame_cnt+1.
- blinking is registered. It is 1 exactly while state==BLINK.
- Pixel classification (combinational on h,v and current state; result registered into rgb):
  - h <= PANEL_X: COL_BG.
  - Panel region, in bar k's rectangle (BAR_X_LO<h<BAR_X_HI, BAR_Y0-k*BAR_PITCH < v <= BAR_Y0-k*BAR_PITCH+BAR_H, k<NBARS):
    - IDLE: COL_BAR if k<shown, else COL_PANEL.
    - BLINK, k < min(prev,shown): COL_BAR (solid).
    - BLINK, min <= k < max(prev,shown): COL_BAR when (frame_cnt/BLINK_PERIOD) is even, else COL_PANEL. This applies to gained and lost bars alike.
    - BLINK, k >= max: COL_PANEL.
  - Panel region, outside all bar rectangles: COL_PANEL.
- Arithmetic:
  - Bar row bounds are computed at 11-bit signed width, so k*BAR_PITCH above BAR_Y0 never wraps.
  - Bars whose range falls below row 0 are never drawn.
- Latency:
  - rgb for input (h,v) at cycle n appears at cycle n+1.
  - A state update at frame start is visible from the pixel following (0,0). Pixel (0,0) is always COL_BG under the default parameters.
- Mid-frame level changes have no effect until the next frame start.

Test Plan:
- Reset -> rgb=000000, blinking=0. Release with level=0, drive (500,457) -> rgb=880000 one cycle later; (100,100) -> 000000.
- level=2 held for more than 33 frames, then drive the following pixels:
  - (560,457) and (560,447) -> 99FFFF.
  - (560,437) and (560,452) (gap row) -> 880000.
  - (540,457) (boundary column) -> 880000.
  - (480,457) -> 000000.
- Change level 1->3 at mid-frame -> no change until the next (0,0). Then blinking=1 and bars 1,2 at (560,447)/(560,437) show the following colours:
  - 99FFFF for frames 0-7, 880000 for frames 8-15, repeating.
  - Bar 0 is solid throughout.
  - After 32 frames: blinking=0, bars 0-2 solid.
- Change level 3->1 -> bars 1,2 blink, then read 880000 after 32 frames. Changing level to 2 at frame 10 of the blink -> restart with prev=1, shown=2, only bar 1 blinking.
- level=9 with NBARS=5 -> 5 bars drawn (rows 456..459 through 416..419). (560,407) -> 880000.
- Assert rst_n=0 mid-blink, mid-line -> rgb=000000 and blinking=0 without waiting for a clock. After release, level=0 shows no bars.

Source files
------------

// File: rtl/side_panel_bars_if.sv
// Pixel bus between the raster timing / RGB mux side and the status-panel
// renderer.
//   h, v      : current pixel column and row
//   level     : requested bar count, saturated inside the renderer
//   rgb       : registered pixel colour, one cycle behind (h, v)
//   blinking  : high while a bar-count change is being highlighted
interface side_panel_bars_if #(
  parameter int LW = 4
);
  logic [9:0]    h;
  logic [9:0]    v;
  logic [LW-1:0] level;
  logic [23:0]   rgb;
  logic          blinking;

  // Raster side: drives coordinates and level, consumes colour.
  modport master (output h, v, level, input rgb, blinking);
  // Renderer side.
  modport slave  (input h, v, level, output rgb, blinking);
endinterface

// File: rtl/side_panel_bars.sv
// Status-panel renderer for the right-hand side of a 640x480 display.
// Draws a stack of horizontal indicator bars over the panel background.
// The bar count is latched once per frame, on the (0,0) pixel, so a frame
// never tears. After every change the bars between the old and the new
// count blink for BLINK_FRAMES frames.
// Ports:
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of side_panel_bars_if (h, v, level in; rgb, blinking out)
module side_panel_bars #(
  parameter int          NBARS        = 5,
  parameter int          LW           = 4,
  parameter int          PANEL_X      = 480,
  parameter int          BAR_X_LO     = 540,
  parameter int          BAR_X_HI     = 580,
  parameter int          BAR_Y0       = 455,
  parameter int          BAR_H        = 4,
  parameter int          BAR_PITCH    = 10,
  parameter int          BLINK_PERIOD = 8,
  parameter int          BLINK_FRAMES = 32,
  parameter logic [23:0] COL_BG       = 24'h000000,
  parameter logic [23:0] COL_PANEL    = 24'h880000,
  parameter logic [23:0] COL_BAR      = 24'h99FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  side_panel_bars_if.slave bus
);

  localparam int CW = 4;                      // holds 0..15 bars
  localparam int FW = $clog2(BLINK_FRAMES);
  localparam int PW = $clog2(BLINK_PERIOD);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   shown_r, shown_nxt_s;
  logic [CW-1:0]   prev_r, prev_nxt_s;
  logic [FW-1:0]   frame_cnt_r, frame_cnt_nxt_s;
  logic [CW-1:0]   lvl_s;
  logic            frame_start_s;

  logic            col_hit_s;
  logic            row_hit_s;
  logic            bar_hit_s;
  logic [CW-1:0]   bar_idx_s;
  logic [CW-1:0]   lo_s, hi_s;
  logic [FW-1:0]   phase_cnt_s;
  logic            phase_on_s;
  logic [23:0]     pix_s;

  logic [23:0]     rgb_r;
  logic            blinking_r;

  assign frame_start_s = (bus.h == 10'd0) && (bus.v == 10'd0);

  // Saturate the requested level to the number of drawable bars.
  always_comb begin
    lvl_s = '0;
    if (int'(bus.level) > NBARS) begin
      lvl_s = CW'(NBARS);
    end else begin
      lvl_s = CW'(bus.level);
    end
  end

  // State, latched counts and blink frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shown_r     <= '0;
      prev_r      <= '0;
      frame_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      shown_r     <= shown_nxt_s;
      prev_r      <= prev_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
    end
  end

  // Next-state logic; everything only moves on a frame start.
  always_comb begin
    state_nxt_s     = state_r;
    shown_nxt_s     = shown_r;
    prev_nxt_s      = prev_r;
    frame_cnt_nxt_s = frame_cnt_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s && (lvl_s != shown_r)) begin
          prev_nxt_s      = shown_r;
          shown_nxt_s     = lvl_s;
          frame_cnt_nxt_s = '0;
          state_nxt_s     = BLINK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BLINK: begin
        if (!frame_start_s) begin
          state_nxt_s = BLINK;
        end else if (lvl_s != shown_r) begin
          // A new change during a blink restarts it from the current count.
          prev_nxt_s      = shown_r;
          shown_nxt_s     = lvl_s;
          frame_cnt_nxt_s = '0;
          state_nxt_s     = BLINK;
        end else if (frame_cnt_r == FW'(BLINK_FRAMES - 1)) begin
          prev_nxt_s  = shown_r;
          state_nxt_s = IDLE;
        end else begin
          frame_cnt_nxt_s = frame_cnt_r + FW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Find which bar rectangle (if any) the current row falls in. Row bounds
  // are evaluated as 11-bit signed values so bars stacked above row 0 go
  // negative instead of wrapping, and simply never match.
  always_comb begin
    col_hit_s = (bus.h > 10'(BAR_X_LO)) && (bus.h < 10'(BAR_X_HI));
    row_hit_s = 1'b0;
    bar_hit_s = 1'b0;
    bar_idx_s = '0;
    for (int k = 0; k < NBARS; k++) begin
      row_hit_s = ($signed({1'b0, bus.v}) >  $signed(11'(BAR_Y0 - k * BAR_PITCH))) &&
                  ($signed({1'b0, bus.v}) <= $signed(11'(BAR_Y0 - k * BAR_PITCH + BAR_H)));
      bar_idx_s = (row_hit_s && !bar_hit_s) ? CW'(k) : bar_idx_s;
      bar_hit_s = bar_hit_s | row_hit_s;
    end
  end

  // Pixel colour. Bars between the old and new count blink, whether they
  // were gained or lost; the phase flips every BLINK_PERIOD frames.
  always_comb begin
    lo_s        = (prev_r < shown_r) ? prev_r : shown_r;
    hi_s        = (prev_r < shown_r) ? shown_r : prev_r;
    phase_cnt_s = frame_cnt_r >> PW;
    phase_on_s  = ~phase_cnt_s[0];
    pix_s       = COL_BG;
    if (bus.h <= 10'(PANEL_X)) begin
      pix_s = COL_BG;
    end else if (col_hit_s && bar_hit_s) begin
      case (state_r)
        IDLE: begin
          pix_s = (bar_idx_s < shown_r) ? COL_BAR : COL_PANEL;
        end
        BLINK: begin
          if (bar_idx_s < lo_s) begin
            pix_s = COL_BAR;
          end else if (bar_idx_s < hi_s) begin
            pix_s = phase_on_s ? COL_BAR : COL_PANEL;
          end else begin
            pix_s = COL_PANEL;
          end
        end
        default: begin
          pix_s = COL_PANEL;
        end
      endcase
    end else begin
      pix_s = COL_PANEL;
    end
  end

  // Output registers; blinking follows the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r      <= 24'h000000;
      blinking_r <= 1'b0;
    end else begin
      rgb_r      <= pix_s;
      blinking_r <= (state_nxt_s == BLINK);
    end
  end

  assign bus.rgb      = rgb_r;
  assign bus.blinking = blinking_r;

endmodule

// File: tb/tb_side_panel_bars.sv
module tb_side_panel_bars;

  localparam logic [23:0] BG  = 24'h000000;
  localparam logic [23:0] PAN = 24'h880000;
  localparam logic [23:0] BAR = 24'h99FFFF;

  typedef struct {
    string       name;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [23:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [23:0] sb[$];
  vec_t tbl[$];

  side_panel_bars_if #(.LW(4)) bus ();

  side_panel_bars dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check24(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Present one pixel, record its expected colour, compare one cycle later.
  task automatic chk_pix(input string name, input logic [9:0] hh, input logic [9:0] vv,
                         input logic [23:0] exp);
    logic [23:0] e;
    bus.h = hh;
    bus.v = vv;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check24(name, bus.rgb, e);
  endtask

  // One frame start: pixel (0,0) itself is always background.
  task automatic frame_start();
    chk_pix("pix00", 10'd0, 10'd0, BG);
    bus.h = 10'd100;
    bus.v = 10'd100;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_start();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      chk_pix({tag, "_", tbl[i].name}, tbl[i].h, tbl[i].v, tbl[i].exp);
    tbl.delete();
  endtask

  function automatic logic [23:0] phase_col(input int f);
    return (((f / 8) % 2) == 0) ? BAR : PAN;
  endfunction

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.level = 4'd0;
    bus.h     = 10'd100;
    bus.v     = 10'd100;
    #3;
    check24("reset_rgb", bus.rgb, BG);
    check1("reset_blinking", bus.blinking, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk_pix("lvl0_panel", 10'd500, 10'd457, PAN);
    chk_pix("lvl0_bg", 10'd100, 10'd100, BG);
    check1("lvl0_blinking", bus.blinking, 1'b0);

    // Two bars, held well past the blink.
    bus.level = 4'd2;
    frame_start();
    check1("lvl2_blink_on", bus.blinking, 1'b1);
    frames(33);
    check1("lvl2_blink_off", bus.blinking, 1'b0);
    tbl.push_back('{"bar0",    10'd560, 10'd457, BAR});
    tbl.push_back('{"bar1",    10'd560, 10'd447, BAR});
    tbl.push_back('{"bar2",    10'd560, 10'd437, PAN});
    tbl.push_back('{"gap",     10'd560, 10'd452, PAN});
    tbl.push_back('{"col540",  10'd540, 10'd457, PAN});
    tbl.push_back('{"col541",  10'd541, 10'd457, BAR});
    tbl.push_back('{"col579",  10'd579, 10'd457, BAR});
    tbl.push_back('{"col580",  10'd580, 10'd457, PAN});
    tbl.push_back('{"h480",    10'd480, 10'd457, BG});
    tbl.push_back('{"h481",    10'd481, 10'd300, PAN});
    tbl.push_back('{"row456",  10'd560, 10'd456, BAR});
    tbl.push_back('{"row455",  10'd560, 10'd455, PAN});
    tbl.push_back('{"row459",  10'd560, 10'd459, BAR});
    tbl.push_back('{"row460",  10'd560, 10'd460, PAN});
    run_table("lvl2");

    // Settle at one bar, then request three in mid-frame.
    bus.level = 4'd1;
    frames(34);
    chk_pix("lvl1_bar1", 10'd560, 10'd447, PAN);
    bus.level = 4'd3;
    chk_pix("mid_bar1", 10'd560, 10'd447, PAN);
    chk_pix("mid_bar0", 10'd560, 10'd457, BAR);
    check1("mid_blinking", bus.blinking, 1'b0);
    frame_start();
    for (int f = 0; f < 32; f++) begin
      check1("up_blinking", bus.blinking, 1'b1);
      chk_pix("up_bar0", 10'd560, 10'd457, BAR);
      chk_pix("up_bar1", 10'd560, 10'd447, phase_col(f));
      chk_pix("up_bar2", 10'd560, 10'd437, phase_col(f));
      frame_start();
    end
    check1("up_done_blinking", bus.blinking, 1'b0);
    chk_pix("up_done_bar0", 10'd560, 10'd457, BAR);
    chk_pix("up_done_bar1", 10'd560, 10'd447, BAR);
    chk_pix("up_done_bar2", 10'd560, 10'd437, BAR);
    chk_pix("up_done_bar3", 10'd560, 10'd427, PAN);

    // Drop to one bar, then go to two at blink frame 10.
    bus.level = 4'd1;
    frame_start();
    for (int f = 0; f < 10; f++) begin
      chk_pix("dn_bar0", 10'd560, 10'd457, BAR);
      chk_pix("dn_bar1", 10'd560, 10'd447, phase_col(f));
      chk_pix("dn_bar2", 10'd560, 10'd437, phase_col(f));
      frame_start();
    end
    bus.level = 4'd2;
    frame_start();
    check1("rs_blinking", bus.blinking, 1'b1);
    chk_pix("rs_bar0", 10'd560, 10'd457, BAR);
    chk_pix("rs_bar1", 10'd560, 10'd447, BAR);
    chk_pix("rs_bar2", 10'd560, 10'd437, PAN);
    frames(8);
    chk_pix("rs8_bar0", 10'd560, 10'd457, BAR);
    chk_pix("rs8_bar1", 10'd560, 10'd447, PAN);
    chk_pix("rs8_bar2", 10'd560, 10'd437, PAN);
    frames(24);
    check1("rs_done_blinking", bus.blinking, 1'b0);
    chk_pix("rs_done_bar1", 10'd560, 10'd447, BAR);
    chk_pix("rs_done_bar2", 10'd560, 10'd437, PAN);

    // Lost bar reads as panel once its blink has finished.
    bus.level = 4'd1;
    frames(33);
    check1("lost_blinking", bus.blinking, 1'b0);
    chk_pix("lost_bar0", 10'd560, 10'd457, BAR);
    chk_pix("lost_bar1", 10'd560, 10'd447, PAN);

    // Saturation: 9 requested, 5 drawn.
    bus.level = 4'd9;
    frames(34);
    check1("sat_blinking", bus.blinking, 1'b0);
    tbl.push_back('{"bar0_456", 10'd560, 10'd456, BAR});
    tbl.push_back('{"bar0_459", 10'd560, 10'd459, BAR});
    tbl.push_back('{"bar4_416", 10'd560, 10'd416, BAR});
    tbl.push_back('{"bar4_419", 10'd560, 10'd419, BAR});
    tbl.push_back('{"bar4_415", 10'd560, 10'd415, PAN});
    tbl.push_back('{"bar3_427", 10'd560, 10'd427, BAR});
    tbl.push_back('{"bar5_407", 10'd560, 10'd407, PAN});
    run_table("sat");

    // Asynchronous reset in the middle of a blink and a line.
    bus.level = 4'd0;
    frame_start();
    check1("pre_rst_blinking", bus.blinking, 1'b1);
    chk_pix("pre_rst_bar0", 10'd560, 10'd457, BAR);
    bus.h = 10'd560;
    bus.v = 10'd457;
    #2;
    rst_n = 1'b0;
    #1;
    check24("async_rst_rgb", bus.rgb, BG);
    check1("async_rst_blinking", bus.blinking, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_pix("post_rst_bar0", 10'd560, 10'd457, PAN);
    frame_start();
    check1("post_rst_blinking", bus.blinking, 1'b0);
    chk_pix("post_rst_bar1", 10'd560, 10'd447, PAN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
